// File: rtl/mem_pkg.sv
// Shared geometry of the 8x8 single-port mem and the FIFO sequencer in front of it.
package mem_pkg;

  localparam int MEM_AW    = 3;
  localparam int MEM_DW    = 8;
  localparam int MEM_DEPTH = 1 << MEM_AW;

  typedef logic [MEM_AW-1:0] mem_addr_t;
  typedef logic [MEM_DW-1:0] mem_data_t;

endpackage : mem_pkg

// File: rtl/mem_fifo_ctrl.sv
// FIFO sequencer: turns a push/pop stream into single-port mem accesses.
// Owns read/write pointers and occupancy; mem is treated as plain storage.
// At most one mem operation per cycle, and pop wins over push.
module mem_fifo_ctrl
  import mem_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  output logic          push_ready,
  input  logic          pop,
  output logic          pop_ready,
  output logic [DW-1:0] rdata,
  output logic          rdata_valid,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          mem_wr,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam int          DEPTH      = 1 << AW;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_rd_pend;
  logic [DW-1:0] r_rdata;

  logic w_empty;
  logic w_full;
  logic w_pop_acc;
  logic w_push_acc;

  // Flags come straight from the registered occupancy.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_COUNT);

  // Pop has priority: a pending pop on a non-empty FIFO blocks the push.
  assign pop_ready  = !rst && !w_empty;
  assign push_ready = !rst && !w_full && !(pop && !w_empty);
  assign w_pop_acc  = pop && pop_ready;
  assign w_push_acc = push && push_ready;

  // Issue mux: the address idles on the read pointer when nothing is issued.
  assign mem_rd   = w_pop_acc;
  assign mem_wr   = w_push_acc;
  assign mem_addr = w_push_acc ? r_wptr : r_rptr;
  assign mem_din  = push_data;

  // mem registers Dataout on the read edge, so the data is live in the cycle
  // after acceptance; outside that cycle the last popped word is replayed.
  // A reset landing on the read cycle drops the outstanding read.
  assign rdata_valid = r_rd_pend && !rst;
  assign rdata       = r_rd_pend ? mem_dout : r_rdata;

  assign full  = w_full;
  assign empty = w_empty;
  assign count = r_count;

  // Pointer and occupancy update; push and pop are never accepted together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_pop_acc) begin
      r_rptr  <= r_rptr + 1'b1;
      r_count <= r_count - 1'b1;
    end else if (w_push_acc) begin
      r_wptr  <= r_wptr + 1'b1;
      r_count <= r_count + 1'b1;
    end
  end

  // Track the read in flight and hold the last popped word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_pend <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rd_pend <= w_pop_acc;
      if (r_rd_pend) begin
        r_rdata <= mem_dout;
      end
    end
  end

endmodule : mem_fifo_ctrl

// File: tb/tb_mem_fifo_ctrl.sv
// Self-checking bench for mem_fifo_ctrl with a behavioural 8x8 mem attached.
module tb_mem_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic       push;
  logic [7:0] push_data;
  logic       push_ready;
  logic       pop;
  logic       pop_ready;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       mem_wr;
  logic       mem_rd;
  logic [2:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents as a queue plus simple counters.
  logic [7:0] q[$];
  int         n_push = 0;
  int         n_pop  = 0;
  bit         m_valid = 0;
  logic [7:0] m_rdata = 8'h00;

  // Behavioural single-port mem: registered read, write on wr.
  logic [7:0] mem_arr [0:7];

  mem_fifo_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_data   (push_data),
    .push_ready  (push_ready),
    .pop         (pop),
    .pop_ready   (pop_ready),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .mem_wr      (mem_wr),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr) mem_arr[mem_addr] <= mem_din;
    if (mem_rd) mem_dout <= mem_arr[mem_addr];
  end

  // Expected handshake/issue values from the FIFO rules and the model state.
  function automatic bit e_pop_rdy();
    return !rst && (q.size() > 0);
  endfunction

  function automatic bit e_push_rdy();
    return !rst && (q.size() < 8) && !(pop && (q.size() > 0));
  endfunction

  function automatic logic [2:0] e_addr();
    if (push && e_push_rdy()) return 3'(n_push % 8);
    return 3'(n_pop % 8);
  endfunction

  task automatic set_in(input bit r, input bit p, input logic [7:0] d, input bit po);
    rst = r; push = p; push_data = d; pop = po;
  endtask

  // Advance one clock and update the model with what the rules accept.
  task automatic tick();
    bit pa, wa, r;
    logic [7:0] d;
    r  = rst;
    d  = push_data;
    pa = !rst && pop && (q.size() > 0);
    wa = !rst && push && (q.size() < 8) && !(pop && (q.size() > 0));
    @(posedge clk);
    #1;
    if (r) begin
      q.delete(); n_push = 0; n_pop = 0; m_valid = 0; m_rdata = 8'h00;
    end else begin
      m_valid = pa;
      if (pa) begin m_rdata = q.pop_front(); n_pop++; end
      if (wa) begin q.push_back(d); n_push++; end
    end
  endtask

  task automatic do_reset();
    set_in(1, 0, 8'h00, 0); tick(); tick();
    set_in(0, 0, 8'h00, 0);
  endtask

  task automatic test_reset();
    set_in(1, 1, 8'h5A, 1);
    @(negedge clk);
    checks++;
    if (push_ready !== 1'b0 || pop_ready !== 1'b0 || mem_wr !== 1'b0 || mem_rd !== 1'b0) begin
      errors++;
      $display("FAIL rst_gating: push_ready=%b pop_ready=%b mem_wr=%b mem_rd=%b, required all 0",
               push_ready, pop_ready, mem_wr, mem_rd);
    end
    tick(); tick();
    set_in(0, 0, 8'h00, 0);
    @(negedge clk);
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || mem_wr !== 1'b0 ||
        mem_rd !== 1'b0 || rdata_valid !== 1'b0 || rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_idle: count=%0d empty=%b full=%b wr=%b rd=%b v=%b rdata=%h, required 0 1 0 0 0 0 00",
               count, empty, full, mem_wr, mem_rd, rdata_valid, rdata);
    end
    tick();
  endtask

  task automatic test_ordering();
    logic [7:0] vals [3];
    vals[0] = 8'hA5; vals[1] = 8'h3C; vals[2] = 8'hFF;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, vals[i], 0);
      @(negedge clk);
      checks++;
      if (mem_wr !== 1'b1 || mem_addr !== 3'(i) || mem_din !== vals[i]) begin
        errors++;
        $display("FAIL order_push%0d: wr=%b addr=%0d din=%h, required 1 %0d %h",
                 i, mem_wr, mem_addr, mem_din, i, vals[i]);
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 8'h00, i < 3);
      @(negedge clk);
      checks++;
      if (count !== 4'(3 - i)) begin
        errors++;
        $display("FAIL order_count%0d: count=%0d, required %0d", i, count, 3 - i);
      end
      if (i > 0) begin
        checks++;
        if (rdata_valid !== 1'b1 || rdata !== vals[i-1]) begin
          errors++;
          $display("FAIL order_pop%0d: valid=%b rdata=%h, required 1 %h", i - 1, rdata_valid, rdata, vals[i-1]);
        end
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (empty !== 1'b1 || rdata_valid !== 1'b0) begin
      errors++;
      $display("FAIL order_end: empty=%b valid=%b, required 1 0", empty, rdata_valid);
    end
  endtask

  task automatic test_fill_wrap();
    logic [7:0] exp_out [8];
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      set_in(0, 1, 8'(i), 0); tick();
    end
    set_in(0, 1, 8'h09, 0);
    @(negedge clk);
    checks++;
    if (full !== 1'b1 || push_ready !== 1'b0 || mem_wr !== 1'b0 || count !== 4'd8) begin
      errors++;
      $display("FAIL fill_full: full=%b push_ready=%b wr=%b count=%0d, required 1 0 0 8",
               full, push_ready, mem_wr, count);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 8'h00, 1); tick();
      checks++;
      if (rdata_valid !== 1'b1 || rdata !== 8'(i + 1)) begin
        errors++;
        $display("FAIL wrap_pop%0d: valid=%b rdata=%h, required 1 %h", i, rdata_valid, rdata, 8'(i + 1));
      end
    end
    for (int i = 0; i < 2; i++) begin
      set_in(0, 1, 8'h0A + 8'(i), 0);
      @(negedge clk);
      checks++;
      if (mem_wr !== 1'b1 || mem_addr !== 3'(i)) begin
        errors++;
        $display("FAIL wrap_addr%0d: wr=%b addr=%0d, required 1 %0d", i, mem_wr, mem_addr, i);
      end
      tick();
    end
    for (int i = 0; i < 6; i++) exp_out[i] = 8'(i + 3);
    exp_out[6] = 8'h0A; exp_out[7] = 8'h0B;
    for (int i = 0; i < 8; i++) begin
      set_in(0, 0, 8'h00, 1); tick();
      checks++;
      if (rdata_valid !== 1'b1 || rdata !== exp_out[i] || rdata !== m_rdata) begin
        errors++;
        $display("FAIL wrap_drain%0d: valid=%b rdata=%h, required 1 %h", i, rdata_valid, rdata, exp_out[i]);
      end
    end
    set_in(0, 0, 8'h00, 0); tick();
  endtask

  task automatic test_contention();
    do_reset();
    set_in(0, 1, 8'h11, 0); tick();
    set_in(0, 1, 8'h22, 0); tick();
    set_in(0, 1, 8'h55, 1);
    @(negedge clk);
    checks++;
    if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || push_ready !== 1'b0 || mem_addr !== 3'd0) begin
      errors++;
      $display("FAIL contend_pop: rd=%b wr=%b push_ready=%b addr=%0d, required 1 0 0 0",
               mem_rd, mem_wr, push_ready, mem_addr);
    end
    tick();
    set_in(0, 1, 8'h55, 0);
    @(negedge clk);
    checks++;
    if (push_ready !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 3'd2 || rdata !== 8'h11) begin
      errors++;
      $display("FAIL contend_push: push_ready=%b wr=%b addr=%0d rdata=%h, required 1 1 2 11",
               push_ready, mem_wr, mem_addr, rdata);
    end
    tick();
    set_in(0, 0, 8'h00, 0);
    @(negedge clk);
    checks++;
    if (count !== 4'd2) begin
      errors++;
      $display("FAIL contend_count: count=%0d, required 2", count);
    end
  endtask

  task automatic test_under_over();
    do_reset();
    set_in(0, 0, 8'h00, 1);
    @(negedge clk);
    checks++;
    if (mem_rd !== 1'b0 || pop_ready !== 1'b0) begin
      errors++;
      $display("FAIL underflow_rd: rd=%b pop_ready=%b, required 0 0", mem_rd, pop_ready);
    end
    tick();
    set_in(0, 1, 8'hC3, 1);
    @(negedge clk);
    checks++;
    if (rdata_valid !== 1'b0 || mem_wr !== 1'b1 || mem_rd !== 1'b0) begin
      errors++;
      $display("FAIL underflow_next: valid=%b wr=%b rd=%b, required 0 1 0", rdata_valid, mem_wr, mem_rd);
    end
    tick();
    for (int i = 1; i < 8; i++) begin
      set_in(0, 1, 8'hC3 + 8'(i), 0); tick();
    end
    set_in(0, 1, 8'hEE, 0);
    @(negedge clk);
    checks++;
    if (mem_wr !== 1'b0 || count !== 4'd8) begin
      errors++;
      $display("FAIL overflow_wr: wr=%b count=%0d, required 0 8", mem_wr, count);
    end
    tick();
    set_in(0, 1, 8'hEE, 1);
    @(negedge clk);
    checks++;
    if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 3'd0) begin
      errors++;
      $display("FAIL full_both: rd=%b wr=%b addr=%0d, required 1 0 0", mem_rd, mem_wr, mem_addr);
    end
    tick();
    checks++;
    if (rdata !== 8'hC3 || count !== 4'd7) begin
      errors++;
      $display("FAIL overflow_ptr: rdata=%h count=%0d, required c3 7", rdata, count);
    end
    set_in(0, 0, 8'h00, 0); tick();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 8'h40 + 8'(i), 0); tick();
    end
    set_in(0, 0, 8'h00, 1); tick();
    set_in(1, 0, 8'h00, 0); tick();
    set_in(0, 0, 8'h00, 0);
    @(negedge clk);
    checks++;
    if (rdata_valid !== 1'b0 || count !== 4'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_read: valid=%b count=%0d empty=%b, required 0 0 1", rdata_valid, count, empty);
    end
    tick();
    set_in(0, 1, 8'h77, 0); tick();
    set_in(0, 0, 8'h00, 1); tick();
    checks++;
    if (rdata_valid !== 1'b1 || rdata !== 8'h77) begin
      errors++;
      $display("FAIL rst_recover: valid=%b rdata=%h, required 1 77", rdata_valid, rdata);
    end
    set_in(0, 0, 8'h00, 0); tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_in(0, $urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 45);
      @(negedge clk);
      checks++;
      if (mem_wr && mem_rd) begin
        errors++;
        $display("FAIL rand_single_port%0d: wr=%b rd=%b, required not both", i, mem_wr, mem_rd);
      end
      checks++;
      if (count !== 4'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == 8) ||
          pop_ready !== e_pop_rdy() || push_ready !== e_push_rdy() ||
          mem_rd !== (pop && e_pop_rdy()) || mem_wr !== (push && e_push_rdy()) || mem_addr !== e_addr()) begin
        errors++;
        $display("FAIL rand_ctrl%0d: count=%0d pr=%b wr=%b rd=%b addr=%0d, required count=%0d pr=%b addr=%0d",
                 i, count, push_ready, mem_wr, mem_rd, mem_addr, q.size(), e_push_rdy(), e_addr());
      end
      checks++;
      if (rdata_valid !== m_valid || rdata !== m_rdata) begin
        errors++;
        $display("FAIL rand_data%0d: valid=%b rdata=%h, required %b %h", i, rdata_valid, rdata, m_valid, m_rdata);
      end
      tick();
    end
  endtask

  initial begin
    set_in(1, 0, 8'h00, 0);
    mem_dout = 8'h00;
    test_reset();
    test_ordering();
    test_fill_wrap();
    test_contention();
    test_under_over();
    test_reset_mid_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mem_fifo_ctrl
